// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver: a serial deserialiser feeding a small receive FIFO.
// Software polls STATUS and pops received bytes through DATA.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4,
    parameter int IO_CTRL_BIT  = 22,
    parameter int UART_RX_BIT  = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_rstrb_i,
    output logic [31:0] mem_rdata_o,
    input  logic [3:0]  mem_wmask_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        rx_i
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] HALF_BIT  = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_BIT  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
    localparam logic [CNT_W-1:0]  DEPTH     = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic              sync_r;
    logic              rxs_r;
    logic              rxs_d_r;
    state_t            state_r;
    logic [BAUD_W-1:0] baud_r;
    logic [2:0]        bit_r;
    logic [7:0]        shift_r;

    logic [7:0]        fifo_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              overrun_r;
    logic              frame_err_r;

    logic        sel_s;
    logic        rd_data_s;
    logic        wr_status_s;
    logic        empty_s;
    logic        full_s;
    logic        pop_s;
    logic        stop_s;
    logic        push_s;
    logic        ovr_set_s;
    logic        ferr_set_s;
    logic [31:0] status_s;
    logic        unused_s;

    assign sel_s       = mem_addr_i[IO_CTRL_BIT] & mem_addr_i[UART_RX_BIT];
    assign rd_data_s   = mem_rstrb_i & sel_s & ~mem_addr_i[2];
    assign wr_status_s = (mem_wmask_i != 4'b0000) & mem_wmask_i[0] & sel_s & mem_addr_i[2];
    assign empty_s     = (count_r == CNT_ZERO);
    assign full_s      = (count_r == DEPTH);
    assign pop_s       = rd_data_s & ~empty_s;
    assign stop_s      = (state_r == STOP) && (baud_r == FULL_BIT);
    // A same-cycle pop frees a slot, so a full FIFO still accepts the push
    assign push_s      = stop_s & rxs_r & (~full_s | pop_s);
    assign ovr_set_s   = stop_s & rxs_r & full_s & ~pop_s;
    assign ferr_set_s  = stop_s & ~rxs_r;
    assign status_s    = {28'h0000000, frame_err_r, overrun_r, full_s, ~empty_s};
    assign unused_s    = ^{mem_addr_i, mem_wdata_i};

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sync_r  <= 1'b1;
            rxs_r   <= 1'b1;
            rxs_d_r <= 1'b1;
        end else begin
            sync_r  <= rx_i;
            rxs_r   <= sync_r;
            rxs_d_r <= rxs_r;
        end
    end

    // Receive FSM: start on a falling edge so a line stuck low cannot retrigger
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r <= IDLE;
            baud_r  <= BAUD_ZERO;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!rxs_r && rxs_d_r) begin
                        state_r <= START;
                        baud_r  <= BAUD_ZERO;
                    end
                end
                START: begin
                    if (baud_r == HALF_BIT) begin
                        baud_r  <= BAUD_ZERO;
                        bit_r   <= 3'd0;
                        state_r <= rxs_r ? IDLE : DATA;
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_r == FULL_BIT) begin
                        baud_r  <= BAUD_ZERO;
                        shift_r <= {rxs_r, shift_r[7:1]};
                        bit_r   <= bit_r + 3'd1;
                        if (bit_r == 3'd7) begin
                            state_r <= STOP;
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_r == FULL_BIT) begin
                        baud_r  <= BAUD_ZERO;
                        state_r <= IDLE;
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    baud_r  <= BAUD_ZERO;
                end
            endcase
        end
    end

    // FIFO storage, written only on an accepted push
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_r[wr_ptr_r] <= shift_r;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error flags; a set in the same cycle beats write-1-to-clear
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (wr_status_s && mem_wdata_i[2]) begin
                overrun_r <= 1'b0;
            end
            if (ferr_set_s) begin
                frame_err_r <= 1'b1;
            end else if (wr_status_s && mem_wdata_i[3]) begin
                frame_err_r <= 1'b0;
            end
        end
    end

    // Registered read data; holds between strobed reads
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mem_rdata_o <= 32'h00000000;
        end else if (mem_rstrb_i) begin
            if (!sel_s) begin
                mem_rdata_o <= 32'h00000000;
            end else if (mem_addr_i[2]) begin
                mem_rdata_o <= status_s;
            end else if (!empty_s) begin
                mem_rdata_o <= {24'h000000, fifo_r[rd_ptr_r]};
            end else begin
                mem_rdata_o <= 32'h00000000;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx with a short bit period and a 4-entry FIFO.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam logic [31:0] DATA_ADDR  = 32'h0040_0008;
    localparam logic [31:0] STAT_ADDR  = 32'h0040_000C;
    localparam logic [31:0] NOSEL_ADDR = 32'h0000_0008;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] mem_addr_i;
    logic        mem_rstrb_i;
    logic [31:0] mem_rdata_o;
    logic [3:0]  mem_wmask_i;
    logic [31:0] mem_wdata_i;
    logic        rx_i;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4),
        .IO_CTRL_BIT (22),
        .UART_RX_BIT (3)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .mem_addr_i (mem_addr_i),
        .mem_rstrb_i(mem_rstrb_i),
        .mem_rdata_o(mem_rdata_o),
        .mem_wmask_i(mem_wmask_i),
        .mem_wdata_i(mem_wdata_i),
        .rx_i       (rx_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; strobe is sampled on the next posedge, data returned one negedge later
    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        mem_addr_i  = addr;
        mem_rstrb_i = 1'b1;
        @(negedge clk_i);
        mem_rstrb_i = 1'b0;
        data = mem_rdata_o;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] mask);
        mem_addr_i  = addr;
        mem_wdata_i = wdata;
        mem_wmask_i = mask;
        @(negedge clk_i);
        mem_wmask_i = 4'b0000;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx_i = 1'b0;
        repeat (CPB) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (CPB) @(negedge clk_i);
        end
        rx_i = stop_bit;
        repeat (CPB) @(negedge clk_i);
        rx_i = 1'b1;
    endtask

    initial begin
        rst_i       = 1'b0;
        rx_i        = 1'b1;
        mem_addr_i  = 32'h0;
        mem_rstrb_i = 1'b0;
        mem_wmask_i = 4'b0000;
        mem_wdata_i = 32'h0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;

        // Reset state and empty-FIFO reads
        check("reset_rdata", mem_rdata_o, 32'h0);
        bus_read(STAT_ADDR, rd);  check("reset_status", rd, 32'h0);
        bus_read(DATA_ADDR, rd);  check("empty_data", rd, 32'h0);
        bus_read(STAT_ADDR, rd);  check("empty_no_pop", rd, 32'h0);

        // Single byte: push lands on the 155th edge after rx falls (t0 + 8 + 9*16, t0 = 3rd edge)
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (154) @(negedge clk_i);
                bus_read(STAT_ADDR, rd);  check("status_at_push_edge", rd, 32'h0);
                bus_read(STAT_ADDR, rd);  check("status_after_push", rd, 32'h1);
            end
        join
        bus_read(DATA_ADDR, rd);  check("data_a5", rd, 32'h0000_00A5);
        bus_read(STAT_ADDR, rd);  check("status_after_pop", rd, 32'h0);

        // Fill and overrun: 0x05 is dropped
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
        bus_read(STAT_ADDR, rd);  check("full_overrun", rd, 32'h7);
        for (int b = 1; b <= 4; b++) begin
            bus_read(DATA_ADDR, rd);  check("fill_order", rd, 32'(b));
        end
        bus_read(STAT_ADDR, rd);  check("overrun_sticky", rd, 32'h4);
        bus_write(STAT_ADDR, 32'h4, 4'b0010);
        bus_read(STAT_ADDR, rd);  check("w1c_needs_mask0", rd, 32'h4);
        bus_write(STAT_ADDR, 32'h4, 4'b0001);
        bus_read(STAT_ADDR, rd);  check("overrun_cleared", rd, 32'h0);

        // Frame error, then a good frame
        send_frame(8'h3C, 1'b0);
        repeat (CPB) @(negedge clk_i);
        bus_read(STAT_ADDR, rd);  check("frame_err", rd, 32'h8);
        bus_read(DATA_ADDR, rd);  check("ferr_no_push", rd, 32'h0);
        send_frame(8'h3C, 1'b1);
        bus_read(STAT_ADDR, rd);  check("ferr_plus_byte", rd, 32'h9);
        bus_read(DATA_ADDR, rd);  check("data_3c", rd, 32'h0000_003C);
        bus_write(STAT_ADDR, 32'h8, 4'b0001);
        bus_read(STAT_ADDR, rd);  check("ferr_cleared", rd, 32'h0);

        // Glitch shorter than half a bit
        rx_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (3 * CPB) @(negedge clk_i);
        bus_read(STAT_ADDR, rd);  check("glitch_ignored", rd, 32'h0);

        // Reset during data bit 3 of 0xF7; line stays high after release
        send_frame(8'h5A, 1'b1);
        bus_read(STAT_ADDR, rd);  check("pre_reset_status", rd, 32'h1);
        fork
            send_frame(8'hF7, 1'b1);
            begin
                repeat (66) @(negedge clk_i);
                rst_i = 1'b0;
                repeat (18) @(negedge clk_i);
                rst_i = 1'b1;
            end
        join
        check("reset_clears_rdata", mem_rdata_o, 32'h0);
        repeat (2 * CPB) @(negedge clk_i);
        bus_read(STAT_ADDR, rd);  check("reset_mid_frame", rd, 32'h0);

        // Full FIFO with a pop in the same cycle as the stop-bit push
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        bus_read(STAT_ADDR, rd);  check("full_no_overrun", rd, 32'h3);
        fork
            send_frame(8'h55, 1'b1);
            begin
                repeat (154) @(negedge clk_i);
                bus_read(DATA_ADDR, rd);  check("simul_pop_head", rd, 32'h11);
            end
        join
        bus_read(STAT_ADDR, rd);  check("simul_no_overrun", rd, 32'h3);
        bus_read(DATA_ADDR, rd);  check("simul_order_22", rd, 32'h22);
        bus_read(DATA_ADDR, rd);  check("simul_order_33", rd, 32'h33);
        bus_read(DATA_ADDR, rd);  check("simul_order_44", rd, 32'h44);
        bus_read(NOSEL_ADDR, rd); check("nosel_zero", rd, 32'h0);
        bus_read(DATA_ADDR, rd);  check("nosel_no_pop", rd, 32'h55);
        bus_read(STAT_ADDR, rd);  check("final_empty", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
